// File: rtl/sd_cmd_resp_rx.sv
// SD card CMD-line response receiver: waits for a start bit, deserialises a
// 48-bit response frame, checks CRC7 and framing, and reports via Done and flags.
module sd_cmd_resp_rx #(
   parameter int unsigned NCR_MAX = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic        BITEN,
   input  logic        CMD_IN,
   output logic        Busy,
   output logic        Done,
   output logic        Timeout,
   output logic        Crc_Err,
   output logic        Frame_Err,
   output logic [5:0]  Index,
   output logic [31:0] Arg,
   output logic [6:0]  Crc_Rx
);

   localparam int unsigned WCW = ($clog2(NCR_MAX + 1) > 7) ? $clog2(NCR_MAX + 1) : 7;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_START,
      RECEIVE,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WCW-1:0]   wait_inc;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic [6:0]       crc_q, crc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             crc_err_q, crc_err_d;
   logic             frame_err_q, frame_err_d;
   logic [5:0]       index_q, index_d;
   logic [31:0]      arg_q, arg_d;
   logic [6:0]       crc_rx_q, crc_rx_d;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   assign wait_inc = wait_cnt_q + WCW'(1);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      crc_d       = crc_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      timeout_d   = timeout_q;
      crc_err_d   = crc_err_q;
      frame_err_d = frame_err_q;
      index_d     = index_q;
      arg_d       = arg_q;
      crc_rx_d    = crc_rx_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d     = WAIT_START;
               busy_d      = 1'b1;
               timeout_d   = 1'b0;
               crc_err_d   = 1'b0;
               frame_err_d = 1'b0;
               wait_cnt_d  = '0;
            end
         end

         WAIT_START: begin
            if (BITEN) begin
               if (!CMD_IN) begin
                  // Start bit is 0, so the CRC seeded from zero stays zero after it.
                  state_d   = RECEIVE;
                  bit_cnt_d = 6'd1;
                  crc_d     = '0;
               end else if (wait_inc == WCW'(NCR_MAX)) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  wait_cnt_d = wait_inc;
               end
            end
         end

         RECEIVE: begin
            if (BITEN) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q <= 6'd39) begin
                  crc_d = crc7_step(crc_q, CMD_IN);
               end
               if (bit_cnt_q == 6'd1) begin
                  if (CMD_IN) begin
                     frame_err_d = 1'b1;
                  end
               end else if (bit_cnt_q <= 6'd7) begin
                  index_d = {index_q[4:0], CMD_IN};
               end else if (bit_cnt_q <= 6'd39) begin
                  arg_d = {arg_q[30:0], CMD_IN};
               end else if (bit_cnt_q <= 6'd46) begin
                  crc_rx_d = {crc_rx_q[5:0], CMD_IN};
               end else begin
                  crc_err_d = (crc_q != crc_rx_q);
                  if (!CMD_IN) begin
                     frame_err_d = 1'b1;
                  end
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         crc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         index_q     <= '0;
         arg_q       <= '0;
         crc_rx_q    <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         crc_q       <= crc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
         index_q     <= index_d;
         arg_q       <= arg_d;
         crc_rx_q    <= crc_rx_d;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Timeout   = timeout_q;
   assign Crc_Err   = crc_err_q;
   assign Frame_Err = frame_err_q;
   assign Index     = index_q;
   assign Arg       = arg_q;
   assign Crc_Rx    = crc_rx_q;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Scoreboard bench for sd_cmd_resp_rx: stimulus pushes expected frame results,
// a monitor pops and compares them on every Done pulse.
module tb_sd_cmd_resp_rx;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Start = 1'b0;
   logic        BITEN = 1'b0;
   logic        CMD_IN = 1'b1;
   logic        Busy, Done, Timeout, Crc_Err, Frame_Err;
   logic [5:0]  Index;
   logic [31:0] Arg;
   logic [6:0]  Crc_Rx;

   sd_cmd_resp_rx #(.NCR_MAX(64)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .BITEN(BITEN), .CMD_IN(CMD_IN),
      .Busy(Busy), .Done(Done), .Timeout(Timeout), .Crc_Err(Crc_Err),
      .Frame_Err(Frame_Err), .Index(Index), .Arg(Arg), .Crc_Rx(Crc_Rx)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [6:0]  crc;
      logic        to;
      logic        ce;
      logic        fe;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   localparam logic [47:0] GOOD    = 48'h11_0000_0900_67;
   localparam logic [47:0] BADARG  = 48'h11_0000_0901_67;
   localparam logic [47:0] BADEND  = 48'h11_0000_0900_66;
   localparam logic [47:0] BADTX   = 48'h51_0000_0900_67;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                       input logic to, input logic ce, input logic fe);
      exp_t e;
      e.idx = idx; e.arg = arg; e.crc = crc; e.to = to; e.ce = ce; e.fe = fe;
      sb.push_back(e);
   endtask

   // Monitor: every Done pulse must match the oldest expected result.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST && Done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("index",     Index,     e.idx);
               chk("arg",       Arg,       e.arg);
               chk("crc_rx",    Crc_Rx,    e.crc);
               chk("timeout",   Timeout,   e.to);
               chk("crc_err",   Crc_Err,   e.ce);
               chk("frame_err", Frame_Err, e.fe);
               chk("busy_at_done", Busy, 1'b0);
            end
         end
      end
   end

   task automatic send_bit(input logic b, input int gap);
      @(negedge CLK);
      Start  = 1'b0;
      BITEN  = 1'b1;
      CMD_IN = b;
      repeat (gap) begin
         @(negedge CLK);
         BITEN = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [47:0] f, input int gap, input int nbits);
      for (int i = 47; i >= 48 - nbits; i--) send_bit(f[i], gap);
   endtask

   task automatic do_start();
      @(negedge CLK);
      Start = 1'b1;
      BITEN = 1'b0;
      CMD_IN = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      chk("busy_after_start", Busy, 1'b1);
      chk("flags_cleared", {Timeout, Crc_Err, Frame_Err}, 3'b000);
   endtask

   task automatic wait_idle();
      @(negedge CLK);
      BITEN  = 1'b0;
      CMD_IN = 1'b1;
      for (int i = 0; i < 20 && Busy; i++) @(negedge CLK);
      if (Busy) chk("wait_idle_bound", 64'd1, 64'd0);
      @(negedge CLK);
   endtask

   task automatic check_all_zero(input string name);
      chk(name, {Busy, Done, Timeout, Crc_Err, Frame_Err, Index, Arg, Crc_Rx}, '0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      #3 check_all_zero("reset_state");
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Good frame after three idle strobes.
      push(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0, 1'b0);
      do_start();
      repeat (3) send_bit(1'b1, 0);
      send_frame(GOOD, 0, 48);
      wait_idle();

      // Argument LSB flipped: CRC mismatch.
      push(6'h11, 32'h0000_0901, 7'h33, 1'b0, 1'b1, 1'b0);
      do_start();
      send_frame(BADARG, 1, 48);
      wait_idle();

      // End bit 0: framing error only.
      push(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0, 1'b1);
      do_start();
      send_frame(BADEND, 0, 48);
      wait_idle();

      // No start bit within 64 strobes: fields keep previous frame.
      push(6'h11, 32'h0000_0900, 7'h33, 1'b1, 1'b0, 1'b0);
      do_start();
      repeat (64) send_bit(1'b1, 0);
      @(negedge CLK);
      BITEN = 1'b0;
      chk("timeout_done_cycle", Done, 1'b1);
      wait_idle();

      // Transmission bit 1: framing error and CRC error.
      push(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b1, 1'b1);
      do_start();
      send_frame(BADTX, 0, 48);
      wait_idle();

      // Sparse strobes with a stray Start mid-frame.
      push(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0, 1'b0);
      do_start();
      for (int i = 47; i >= 0; i--) begin
         send_bit(GOOD[i], 2);
         if (i == 30) Start = 1'b1;
      end
      wait_idle();

      // Reset mid-frame after bit 20: no Done, everything cleared.
      do_start();
      send_frame(GOOD, 2, 21);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1 check_all_zero("async_reset_midframe");
      BITEN = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      repeat (6) @(negedge CLK);
      check_all_zero("idle_after_reset");

      push(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0, 1'b0);
      do_start();
      send_frame(GOOD, 2, 48);
      wait_idle();

      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
